// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift unit (SLL, SRL, SRA, ROL).
// The operand is shifted STEP bits per cycle under a start/busy/done handshake.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request, sampled only while busy is low (IDLE or DONE)
//   flush  - synchronous abort back to IDLE, takes priority over start
//   op     - 00 SLL, 01 SRL, 10 SRA, 11 ROL
//   shamt  - shift amount, 0 .. WIDTH-1
//   din    - operand
//   busy   - high while shifting
//   done   - one-cycle pulse, dout holds the final result
//   dout   - working/result register
module seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               flush,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   din,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // STEP may equal WIDTH, which does not fit in SHAMT_W bits, so compare at 32 bits.
  localparam logic [31:0] STEP_W = 32'(STEP);

  state_t               state_r, state_s;
  logic [WIDTH-1:0]     work_r, work_s;
  logic [SHAMT_W-1:0]   remaining_r, remaining_s;
  logic [1:0]           op_r, op_s;
  logic [SHAMT_W-1:0]   k_s;
  logic [SHAMT_W-1:0]   rem_left_s;

  // One shift step of k bits; rotate takes the upper half of a doubled word.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0]   v,
    input logic [1:0]         o,
    input logic [SHAMT_W-1:0] k
  );
    logic [2*WIDTH-1:0] dbl;
    dbl = {v, v} << k;
    case (o)
      2'b00:   shift_step = v << k;
      2'b01:   shift_step = v >> k;
      2'b10:   shift_step = $signed(v) >>> k;
      2'b11:   shift_step = dbl[2*WIDTH-1:WIDTH];
      default: shift_step = v;
    endcase
  endfunction

  // Step size for this cycle: min(STEP, remaining).
  always_comb begin
    if (32'(remaining_r) < STEP_W) begin
      k_s = remaining_r;
    end else begin
      k_s = STEP_W[SHAMT_W-1:0];
    end
    rem_left_s = remaining_r - k_s;
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_s     = state_r;
    work_s      = work_r;
    remaining_s = remaining_r;
    op_s        = op_r;
    if (flush) begin
      state_s     = ST_IDLE;
      remaining_s = {SHAMT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            work_s      = din;
            remaining_s = shamt;
            op_s        = op;
            if (shamt != {SHAMT_W{1'b0}}) begin
              state_s = ST_SHIFT;
            end else begin
              state_s = ST_DONE;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          work_s      = shift_step(work_r, op_r, k_s);
          remaining_s = rem_left_s;
          if (rem_left_s == {SHAMT_W{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_SHIFT;
          end
        end
        default: begin
          state_s     = ST_IDLE;
          remaining_s = {SHAMT_W{1'b0}};
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      work_r      <= {WIDTH{1'b0}};
      remaining_r <= {SHAMT_W{1'b0}};
      op_r        <= 2'b00;
    end else begin
      state_r     <= state_s;
      work_r      <= work_s;
      remaining_r <= remaining_s;
      op_r        <= op_s;
    end
  end

  assign busy = (state_r == ST_SHIFT);
  assign done = (state_r == ST_DONE);
  assign dout = work_r;

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Multi-cycle, parametrised shift unit supporting logical-left, logical-right, arithmetic-right and rotate-left operations with variable shift amounts. It replaces the fixed shift-left-by-2 branch-offset logic wherever a variable or wider shift is needed, e.g. a shift-instruction execution path or an address scaler. It trades area for latency by shifting STEP bits per cycle under a start/busy/done handshake.

## Interface

- WIDTH, 32: operand and result width in bits; ≥ 2.
- STEP, 1: bits shifted per SHIFT cycle; power of two, 1 ≤ STEP ≤ WIDTH.
- SHAMT_W, $clog2(WIDTH): width of the shift-amount port (derived; do not override).

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request; sampled only when busy is low.
- flush  input  1  synchronous abort; returns FSM to IDLE.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- shamt  input  SHAMT_W  shift amount, 0 to WIDTH-1.
- din  input  WIDTH  operand.
- busy  output  1  high while in SHIFT state.
- done  output  1  one-cycle pulse: dout holds the final result.
- dout  output  WIDTH  working/result register.

## Operation

- States: IDLE, SHIFT, DONE. busy = (state == SHIFT); done = (state == DONE).
- Registers: work (WIDTH), remaining (SHAMT_W), op_q (2).
- IDLE or DONE, start=1: work ← din, remaining ← shamt, op_q ← op; next state SHIFT if shamt ≠ 0, else DONE.
- IDLE, start=0: hold. DONE, start=0: → IDLE. work/dout hold in both.
- SHIFT: k = min(STEP, remaining); work ← work shifted by k per op_q; remaining ← remaining − k; when remaining − k == 0 → DONE, else stay.
- Op rules per step: SLL fills zeros at LSB; SRL fills zeros at MSB; SRA replicates work[WIDTH-1] (sign of the current work value, which equals the sign of the original din); ROL wraps MSBs into LSBs.
- Result equals the single-step combinational result: SLL din<<shamt, SRL din>>shamt, SRA $signed(din)>>>shamt, ROL (din<<shamt)|(din>>(WIDTH-shamt)) with shamt=0 → din.
- start while busy=1: ignored, no queueing.
- op, shamt, din are sampled only on the accepting edge; later changes have no effect.
- flush=1 (any state): next state IDLE, remaining ← 0; work holds; no done pulse. flush has priority over start in the same cycle.
- Reset (rst_n=0, any time incl. mid-SHIFT): state IDLE, work 0, remaining 0, op_q 0 immediately, no clock required.

## Timing

- Reset values: busy 0, done 0, dout 0.
- Start accepted at edge E. For shamt = 0, done is high in the cycle after E, i.e. after 1 edge.
- For shamt > 0, the FSM is in SHIFT for ceil(shamt/STEP) cycles, then DONE. Done rises after ceil(shamt/STEP)+1 edges from E.
- Example: WIDTH=32, STEP=1, shamt=5: busy high 5 cycles, done in the 6th cycle after E.
- Example: STEP=4, shamt=5: one 4-bit step, then one 1-bit step, so busy is high for 2 cycles.
- done is exactly one cycle wide.
- dout is defined only while done=1. It then holds until the next accepted start, including through IDLE.
- During SHIFT, dout shows intermediate values.
- Back-to-back operation: a start asserted during the DONE cycle is accepted. That gives zero idle cycles between operations.
- No combinational path from inputs to outputs. All outputs are registered or decoded from state.

## Test plan

- Reset: hold rst_n=0 mid-SHIFT, asynchronously. Expect busy=0, done=0, dout=0 immediately. Release rst_n; expect the block to stay in IDLE.
- SLL, STEP=1: din=0x0000_0001, shamt=31. Expect busy for 31 cycles, then done with dout=0x8000_0000.
- SRA vs SRL, STEP=4: din=0x8000_00F0, shamt=7.
  - SRA: expect dout=0xFF00_0001 after 2 busy cycles.
  - SRL: expect dout=0x0100_0001.
- ROL with shamt=0, then back-to-back:
  - First op: din=0xDEAD_BEEF, shamt=0. Expect done 1 cycle later with dout=0xDEAD_BEEF.
  - Second op: start asserted in the DONE cycle with ROL, shamt=8. Expect dout=0xADBE_EFDE.
- Ignore and abort:
  - Pulse start with different operands while busy. Expect the original result.
  - Assert flush mid-SHIFT. Expect busy=0 next cycle and no done pulse.
- Random regression: WIDTH ∈ {8, 32}, STEP ∈ {1, 2, 8}, random op/shamt/din. Check dout against the combinational model and done latency against ceil(shamt/STEP)+1.
